// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache memory interface, backed by an on-chip word RAM.
// Accepts single-word writes every cycle in any state and serves fixed-length read
// bursts with a fixed read latency.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   mem_addr       byte address from the cache; word index = mem_addr[MEMADDRBITS+1:2]
//   mem_in         write data
//   mem_rdreq      read request level, sampled only while idle
//   mem_wrreq      write strobe, one word per cycle
//   mem_out        read data, holds its last value when mem_out_valid is low
//   mem_out_valid  mem_out carries a burst word this cycle
//   mem_burstlen   constant BURSTLEN
//   busy           high whenever a burst is in progress (state not idle)
module dcache_mem_responder #(
    parameter int unsigned DATABITS    = 32,
    parameter int unsigned ADDRBITS    = 32,
    parameter int unsigned MEMADDRBITS = 10,
    parameter int unsigned BURSTLEN    = 8,
    parameter int unsigned RDLATENCY   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] mem_addr,
    input  logic [DATABITS-1:0] mem_in,
    input  logic                mem_rdreq,
    input  logic                mem_wrreq,
    output logic [DATABITS-1:0] mem_out,
    output logic                mem_out_valid,
    output logic [15:0]         mem_burstlen,
    output logic                busy
);

    localparam int unsigned Depth = 2 ** MEMADDRBITS;
    localparam logic [15:0] LastIssue = 16'(BURSTLEN - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StGap} state_e;

    state_e                  state_q;
    logic [MEMADDRBITS-1:0]  base_q;
    logic [15:0]             issue_cnt_q;

    logic [DATABITS-1:0]     ram [Depth];
    logic [MEMADDRBITS-1:0]  req_idx;
    logic [MEMADDRBITS-1:0]  rd_idx;

    logic [RDLATENCY-1:0]    pipe_valid_q;
    logic [DATABITS-1:0]     pipe_data_q [RDLATENCY];

    logic                    issue;
    logic                    pending;
    logic                    unused_addr;

    assign req_idx = mem_addr[MEMADDRBITS+1:2];
    // Index arithmetic is MEMADDRBITS wide so bursts wrap around the end of the RAM.
    assign rd_idx  = base_q + MEMADDRBITS'(issue_cnt_q);
    assign issue   = (state_q == StIssue);

    assign unused_addr = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+2], mem_addr[1:0]};

    // Words still in flight ahead of the output stage. When only the output stage is
    // occupied, this is the last valid cycle and the next cycle is the gap.
    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i + 1 < RDLATENCY; i++) begin
            pending = pending | pipe_valid_q[i];
        end
    end

    // RAM contents are not reset; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (mem_wrreq) begin
            ram[req_idx] <= mem_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            issue_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A simultaneous write wins; rdreq is simply re-sampled next cycle.
                    if (mem_rdreq && !mem_wrreq) begin
                        base_q      <= req_idx;
                        issue_cnt_q <= '0;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    issue_cnt_q <= issue_cnt_q + 16'd1;
                    if (issue_cnt_q == LastIssue) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!pending) begin
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Latency pipeline: stage 0 is the RAM read register, the last stage drives mem_out.
    // Data stages load only behind a valid word so mem_out holds between bursts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid_q <= '0;
            for (int unsigned i = 0; i < RDLATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= issue;
            if (issue) begin
                pipe_data_q[0] <= ram[rd_idx];
            end
            for (int unsigned i = 1; i < RDLATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                if (pipe_valid_q[i-1]) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                end
            end
        end
    end

    assign mem_out       = pipe_data_q[RDLATENCY-1];
    assign mem_out_valid = pipe_valid_q[RDLATENCY-1];
    assign mem_burstlen  = 16'(BURSTLEN);
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_dcache_mem_responder.sv
module tb_dcache_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_in = '0;
    logic        rdreq = 1'b0;
    logic        wrreq = 1'b0;
    logic        sw_rdreq = 1'b0;

    logic [31:0] m_out;
    logic        m_valid;
    logic [15:0] m_blen;
    logic        m_busy;
    logic [31:0] a_out;
    logic        a_valid;
    logic [15:0] a_blen;
    logic        a_busy;
    logic [31:0] b_out;
    logic        b_valid;
    logic [15:0] b_blen;
    logic        b_busy;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] model [1024];
    logic [31:0] snap [16];

    always #5 clk = ~clk;

    dcache_mem_responder dut (
        .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_rdreq(rdreq), .mem_wrreq(wrreq), .mem_out(m_out), .mem_out_valid(m_valid),
        .mem_burstlen(m_blen), .busy(m_busy)
    );

    dcache_mem_responder #(.BURSTLEN(16), .RDLATENCY(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_rdreq(sw_rdreq), .mem_wrreq(wrreq), .mem_out(a_out), .mem_out_valid(a_valid),
        .mem_burstlen(a_blen), .busy(a_busy)
    );

    dcache_mem_responder #(.BURSTLEN(1), .RDLATENCY(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_rdreq(sw_rdreq), .mem_wrreq(wrreq), .mem_out(b_out), .mem_out_valid(b_valid),
        .mem_burstlen(b_blen), .busy(b_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr = a;
        mem_in   = d;
        wrreq    = 1'b1;
        tick();
        wrreq    = 1'b0;
        model[a[11:2]] = d;
    endtask

    task automatic take_snap(input logic [31:0] a);
        for (int k = 0; k < 16; k++) begin
            snap[k] = model[10'(a[11:2] + 10'(k))];
        end
    endtask

    // One rdreq pulse on the main instance (BURSTLEN=8, RDLATENCY=2), checked cycle by
    // cycle; optionally writes wr_data to wr_a during cycle wr_cycle of the burst.
    task automatic main_burst(input logic [31:0] a, input string tag, input int wr_cycle,
                              input logic [31:0] wr_a, input logic [31:0] wr_data);
        take_snap(a);
        mem_addr = a;
        rdreq    = 1'b1;
        tick();
        rdreq    = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk({tag, "_valid"}, 64'(m_valid), 64'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) chk({tag, "_data"}, 64'(m_out), 64'(snap[c-3]));
            chk({tag, "_busy"}, 64'(m_busy), 64'(c <= 11));
            if (c == wr_cycle) begin
                mem_addr = wr_a;
                mem_in   = wr_data;
                wrreq    = 1'b1;
                model[wr_a[11:2]] = wr_data;
            end else begin
                wrreq = 1'b0;
            end
            tick();
        end
        wrreq = 1'b0;
    endtask

    initial begin
        int nval;
        int na;
        int nb;

        // Reset state
        tick();
        tick();
        chk("rst_out", 64'(m_out), 64'h0);
        chk("rst_valid", 64'(m_valid), 64'h0);
        chk("rst_busy", 64'(m_busy), 64'h0);
        chk("blen_main", 64'(m_blen), 64'd8);
        chk("blen_a", 64'(a_blen), 64'd16);
        chk("blen_b", 64'(b_blen), 64'd1);
        reset_n = 1'b1;
        tick();

        // Write then read
        for (int i = 0; i < 8; i++) wr(32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
        for (int i = 8; i < 16; i++) wr(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        chk("idle_after_wr", 64'(m_busy), 64'h0);
        main_burst(32'h100, "wr_rd", 0, 32'h0, 32'h0);

        // Chained bursts with rdreq held; address advances per valid word
        take_snap(32'h100);
        mem_addr = 32'h100;
        rdreq    = 1'b1;
        nval     = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (m_valid) begin
                if (nval < 16) begin
                    chk("chain_data", 64'(m_out), 64'(snap[nval]));
                    chk("chain_cycle", 64'(c), 64'(nval < 8 ? 3 + nval : 15 + nval - 8));
                end
                nval++;
                mem_addr = mem_addr + 32'd4;
                if (nval == 16) rdreq = 1'b0;
            end
        end
        rdreq = 1'b0;
        chk("chain_count", 64'(nval), 64'd16);
        chk("chain_idle", 64'(m_busy), 64'h0);

        // Wrap: words 1020..1023 then 0..3; word 0..3 written via aliased addresses
        for (int w = 1020; w < 1024; w++) wr(32'(4 * w), 32'hC0DE_0000 + 32'(w));
        for (int w = 0; w < 4; w++) wr(32'h1003 + 32'(4 * w), 32'hC0DE_0000 + 32'(w));
        main_burst(32'hFF0, "wrap", 0, 32'h0, 32'h0);

        // Collision in idle: write lands, burst starts one cycle later
        for (int i = 1; i < 8; i++) wr(32'h200 + 32'(4 * i), 32'h2000_0000 + 32'(i));
        mem_addr = 32'h200;
        mem_in   = 32'h5A5A_5A5A;
        rdreq    = 1'b1;
        wrreq    = 1'b1;
        tick();
        wrreq    = 1'b0;
        rdreq    = 1'b0;
        model[10'h080] = 32'h5A5A_5A5A;
        chk("coll_not_accepted", 64'(m_busy), 64'h0);
        main_burst(32'h200, "coll", 0, 32'h0, 32'h0);

        // Write during issue to the word issued in that cycle: old data returned
        main_burst(32'h100, "issue_wr", 3, 32'h108, 32'hDEAD_BEEF);
        main_burst(32'h100, "after_issue_wr", 0, 32'h0, 32'h0);

        // Reset after the third valid
        take_snap(32'h100);
        mem_addr = 32'h100;
        rdreq    = 1'b1;
        tick();
        rdreq    = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("mid_valid", 64'(m_valid), 64'(c >= 3));
            if (c >= 3) chk("mid_data", 64'(m_out), 64'(snap[c-3]));
            if (c < 5) tick();
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_valid), 64'h0);
        chk("mid_rst_out", 64'(m_out), 64'h0);
        chk("mid_rst_busy", 64'(m_busy), 64'h0);
        tick();
        tick();
        reset_n = 1'b1;
        nval = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (m_valid) nval++;
        end
        chk("post_rst_valids", 64'(nval), 64'h0);
        chk("post_rst_busy", 64'(m_busy), 64'h0);
        main_burst(32'h100, "ram_kept", 0, 32'h0, 32'h0);

        // Latency sweep: A is RDLATENCY=1/BURSTLEN=16, B is RDLATENCY=8/BURSTLEN=1
        take_snap(32'h100);
        mem_addr = 32'h100;
        sw_rdreq = 1'b1;
        tick();
        sw_rdreq = 1'b0;
        na = 0;
        nb = 0;
        for (int c = 1; c <= 20; c++) begin
            chk("a_valid", 64'(a_valid), 64'(c >= 2 && c <= 17));
            if (a_valid) begin
                na++;
                if (c >= 2 && c <= 17) chk("a_data", 64'(a_out), 64'(snap[c-2]));
            end
            chk("a_busy", 64'(a_busy), 64'(c <= 18));
            chk("b_valid", 64'(b_valid), 64'(c == 9));
            if (b_valid) begin
                nb++;
                chk("b_data", 64'(b_out), 64'(snap[0]));
            end
            chk("b_busy", 64'(b_busy), 64'(c <= 10));
            tick();
        end
        chk("a_count", 64'(na), 64'd16);
        chk("b_count", 64'(nb), 64'd1);
        chk("main_quiet", 64'(m_busy), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the dcache memory interface, i.e. the far end of mem_addr/mem_in/mem_out/mem_rdreq/mem_wrreq/mem_burstlen.
- Backs the interface with an on-chip word RAM.
- Serves single-word writes at one word per cycle, and burst reads of mem_burstlen words with a fixed, parameterised read latency.
- Sits where the memory controller connects to the dcache; used as the simulation and FPGA memory for the cache subsystem.

Parameters:
DATABITS, 32, data word width
ADDRBITS, 32, byte address width
MEMADDRBITS, 10, log2 of RAM depth in words
BURSTLEN, 8, words per read burst, driven on mem_burstlen; legal range 1..65535
RDLATENCY, 2, cycles from RAM read issue to mem_out_valid; legal range 1..8

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
mem_addr  input  ADDRBITS  byte address from the cache
mem_in  input  DATABITS  write data
mem_rdreq  input  1  read request, level; sampled only in IDLE
mem_wrreq  input  1  write strobe, one word per cycle
mem_out  output  DATABITS  read data
mem_out_valid  output  1  mem_out holds a burst word this cycle
mem_burstlen  output  16  constant BURSTLEN
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: mem_out=0, mem_out_valid=0, busy=0, state=IDLE, pipeline valid bits=0, burst counters=0.
- RAM contents are not reset. Reset mid-burst aborts the burst; no valid is emitted after reset release until a new request.
- Addressing: word index = mem_addr[MEMADDRBITS+1:2]. Upper bits and mem_addr[1:0] are ignored, so the index wraps modulo 2**MEMADDRBITS.
- Writes:
  - Every cycle with mem_wrreq=1, in any state, RAM[index(mem_addr)] <= mem_in at the clock edge. Full word; no backpressure.
  - Write and read of the same word in the same cycle: the read returns the old data.
- States:
  - IDLE: if mem_rdreq=1 and mem_wrreq=0, latch base=mem_addr word index, issue_cnt=0, go to ISSUE. If both are high, the write is performed and the read is not accepted; mem_rdreq is re-sampled next cycle.
  - ISSUE: each cycle, read RAM[base+issue_cnt] (wrapping) and push a 1 into the latency pipeline. After BURSTLEN issues go to DRAIN. Issues occur on consecutive cycles; mem_rdreq is ignored here.
  - DRAIN: wait until the pipeline is empty. The cycle after the last mem_out_valid is spent in GAP.
  - GAP: one cycle, then IDLE.
- Read timing:
  - rdreq sampled in IDLE at cycle 0.
  - Word k is issued in cycle 1+k.
  - mem_out_valid is high in cycle 1+k+RDLATENCY, carrying RAM[base+k].
  - Burst valids are contiguous: BURSTLEN consecutive cycles.
- Re-arm: the earliest next rdreq sample is 2 cycles after the last valid.
  - The initiator has by then advanced mem_addr by 4*BURSTLEN.
  - The initiator has also deasserted a finished rdreq, so a level-held rdreq chains bursts without duplication.
- mem_out holds its last value when mem_out_valid=0; benches check data only when valid.
- mem_burstlen = BURSTLEN[15:0], constant, including during reset.
- busy = (state != IDLE).

Test Plan:
- Write then read: write 0x11111111..0x88888888 to byte addresses 0x100..0x11C on consecutive cycles, then pulse rdreq at 0x100 (BURSTLEN=8, RDLATENCY=2).
  -> Valid first high 3 cycles after the rdreq sample, 8 contiguous words in written order, busy low 2 cycles after the last valid.
- Chained bursts: hold rdreq high for 2 bursts, with the bench incrementing mem_addr by 4 on each valid.
  -> Second burst starts at 0x120; exactly 16 valids; none duplicated or missed.
- Wrap: read burst at word index 2**MEMADDRBITS-4 (byte 0xFF0 for MEMADDRBITS=10).
  -> Words 1020..1023 then 0..3.
- Collision: rdreq and wrreq high together in IDLE.
  -> Write lands, burst starts one cycle later.
  - Separately, a write during ISSUE to the word being issued in that cycle -> old data returned.
- Reset mid-burst: assert reset_n=0 after the 3rd valid.
  -> mem_out_valid=0, mem_out=0, busy=0 immediately.
  - After release, no valids without a new rdreq; RAM contents preserved.
- Latency sweep: RDLATENCY=1 and 8, BURSTLEN=1 and 16.
  -> First valid at cycle 1+RDLATENCY, exactly BURSTLEN valids, mem_burstlen=BURSTLEN.
